// File: rtl/display_scan_reader.sv
// Reads back a multiplexed 4-digit 7-segment scan (SEG/y) and rebuilds the BCD frame
// with one-cycle Valid, per-frame error flag and a stale-scan indicator.
module display_scan_reader #(
    parameter int unsigned SETTLE  = 4,
    parameter int unsigned TIMEOUT = 65535
) (
    input  logic        Clk,
    input  logic        RES,
    input  logic [3:0]  SEG,
    input  logic [7:0]  y,
    output logic [15:0] Q,
    output logic [3:0]  DP,
    output logic        Valid,
    output logic        Err,
    output logic        Stale
);

    localparam int unsigned NDIG = 4;
    localparam int unsigned DW   = 4;
    localparam int unsigned SW   = 12;
    localparam int unsigned CW   = 4;
    localparam int unsigned TW   = 20;

    localparam logic [CW-1:0] SETTLE_C  = CW'(SETTLE);
    localparam logic [TW-1:0] TIMEOUT_C = TW'(TIMEOUT);

    typedef enum logic {
        COLLECT = 1'b0,
        COMMIT  = 1'b1
    } state_t;

    state_t state;
    state_t state_nx;

    logic [SW-1:0] s_meta;
    logic [SW-1:0] s;
    logic [SW-1:0] s_prev;

    logic [CW-1:0] stab_cnt;
    logic          strobe_c;

    logic [NDIG-1:0]         seg_s;
    logic [6:0]              abcdefg;
    logic                    dp_s;
    logic [DW-1:0]           digit_c;
    logic                    digit_ok_c;
    logic                    onehot_c;
    logic                    multi_c;

    logic [NDIG-1:0][DW-1:0] shadow;
    logic [NDIG-1:0]         dpsh;
    logic [NDIG-1:0]         seen;
    logic [NDIG-1:0]         seen_nx;
    logic                    ferr;
    logic                    ferr_nx;
    logic                    commit_c;

    logic [TW-1:0] tcnt;
    logic [TW-1:0] tcnt_nx;

    // Two-stage synchroniser for the whole {SEG, y} vector plus a one-cycle history
    always_ff @(posedge Clk or negedge RES) begin
        if (!RES) begin
            s_meta <= '0;
            s      <= '0;
            s_prev <= '0;
        end else begin
            s_meta <= {SEG, y};
            s      <= s_meta;
            s_prev <= s;
        end
    end

    // Stability counter saturates at SETTLE; strobe fires only on the SETTLE-1 -> SETTLE step
    always_ff @(posedge Clk or negedge RES) begin
        if (!RES) begin
            stab_cnt <= '0;
        end else if (s != s_prev) begin
            stab_cnt <= '0;
        end else if (stab_cnt != SETTLE_C) begin
            stab_cnt <= stab_cnt + CW'(1);
        end
    end

    assign strobe_c = (s == s_prev) && (stab_cnt == (SETTLE_C - CW'(1)));

    assign seg_s   = s[SW-1:8];
    assign dp_s    = s[7];
    assign abcdefg = {s[0], s[1], s[2], s[3], s[4], s[5], s[6]};

    assign onehot_c = (seg_s != '0) && ((seg_s & (seg_s - NDIG'(1))) == '0);
    assign multi_c  = (seg_s != '0) && !onehot_c;

    // Segment pattern to BCD; anything outside the ten glyphs maps to F
    always_comb begin
        digit_c    = 4'hF;
        digit_ok_c = 1'b1;
        case (abcdefg)
            7'b1111110: digit_c = 4'd0;
            7'b0110000: digit_c = 4'd1;
            7'b1101101: digit_c = 4'd2;
            7'b1111001: digit_c = 4'd3;
            7'b0110011: digit_c = 4'd4;
            7'b1011011: digit_c = 4'd5;
            7'b1011111: digit_c = 4'd6;
            7'b1110000: digit_c = 4'd7;
            7'b1111111: digit_c = 4'd8;
            7'b1111011: digit_c = 4'd9;
            default: begin
                digit_c    = 4'hF;
                digit_ok_c = 1'b0;
            end
        endcase
    end

    // Shadow digit and decimal-point store, newest capture of a digit wins
    always_ff @(posedge Clk or negedge RES) begin
        if (!RES) begin
            shadow <= '0;
            dpsh   <= '0;
        end else if (strobe_c && onehot_c) begin
            for (int i = 0; i < int'(NDIG); i++) begin
                if (seg_s[i]) begin
                    shadow[i] <= digit_c;
                    dpsh[i]   <= dp_s;
                end
            end
        end
    end

    always_ff @(posedge Clk or negedge RES) begin
        if (!RES) begin
            state <= COLLECT;
        end else begin
            state <= state_nx;
        end
    end

    // Frame sequencing; a capture in the commit cycle lands after the clear
    always_comb begin
        state_nx = state;
        commit_c = 1'b0;
        seen_nx  = seen;
        ferr_nx  = ferr;
        case (state)
            COLLECT: begin
                if (seen == '1) begin
                    commit_c = 1'b1;
                    state_nx = COMMIT;
                end
            end
            COMMIT: begin
                state_nx = COLLECT;
            end
            default: begin
                state_nx = COLLECT;
            end
        endcase
        if (commit_c) begin
            seen_nx = '0;
            ferr_nx = 1'b0;
        end
        if (strobe_c) begin
            if (onehot_c) begin
                seen_nx = seen_nx | seg_s;
                if (!digit_ok_c) begin
                    ferr_nx = 1'b1;
                end
            end else if (multi_c) begin
                ferr_nx = 1'b1;
            end
        end
    end

    always_ff @(posedge Clk or negedge RES) begin
        if (!RES) begin
            seen <= '0;
            ferr <= 1'b0;
        end else begin
            seen <= seen_nx;
            ferr <= ferr_nx;
        end
    end

    always_ff @(posedge Clk or negedge RES) begin
        if (!RES) begin
            Q     <= '0;
            DP    <= '0;
            Err   <= 1'b0;
            Valid <= 1'b0;
        end else begin
            Valid <= commit_c;
            if (commit_c) begin
                Q   <= shadow;
                DP  <= dpsh;
                Err <= ferr;
            end
        end
    end

    // Timeout counter cleared by every capture, blanking included
    always_comb begin
        tcnt_nx = tcnt;
        if (strobe_c) begin
            tcnt_nx = '0;
        end else if (tcnt != TIMEOUT_C) begin
            tcnt_nx = tcnt + TW'(1);
        end
    end

    always_ff @(posedge Clk or negedge RES) begin
        if (!RES) begin
            tcnt  <= '0;
            Stale <= 1'b0;
        end else begin
            tcnt  <= tcnt_nx;
            Stale <= (tcnt_nx == TIMEOUT_C);
        end
    end

endmodule

// File: tb/tb_display_scan_reader.sv
// Directed bench for display_scan_reader: frame assembly, decode errors, glitches, timeout, reset.
module tb_display_scan_reader;

    localparam int unsigned SETTLE  = 4;
    localparam int unsigned TIMEOUT = 100;

    logic        Clk = 1'b0;
    logic        RES = 1'b0;
    logic [3:0]  SEG = '0;
    logic [7:0]  y   = '0;
    logic [15:0] Q;
    logic [3:0]  DP;
    logic        Valid;
    logic        Err;
    logic        Stale;

    int n_cmp = 0;
    int n_bad = 0;
    int vcnt  = 0;
    int v0    = 0;

    always #5 Clk = ~Clk;

    display_scan_reader #(
        .SETTLE  (SETTLE),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .Clk   (Clk),
        .RES   (RES),
        .SEG   (SEG),
        .y     (y),
        .Q     (Q),
        .DP    (DP),
        .Valid (Valid),
        .Err   (Err),
        .Stale (Stale)
    );

    // Counts every cycle Valid is high, so a stretched pulse shows up as an extra count
    always @(negedge Clk) begin
        if (Valid) vcnt++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [6:0] pat(input int d);
        case (d)
            0: pat = 7'b1111110;
            1: pat = 7'b0110000;
            2: pat = 7'b1101101;
            3: pat = 7'b1111001;
            4: pat = 7'b0110011;
            5: pat = 7'b1011011;
            6: pat = 7'b1011111;
            7: pat = 7'b1110000;
            8: pat = 7'b1111111;
            9: pat = 7'b1111011;
            default: pat = 7'b0000000;
        endcase
    endfunction

    // p is written a..g with a as MSB; y[0]=a .. y[6]=g, y[7]=dp
    function automatic logic [7:0] mk_y(input logic [6:0] p, input logic dp);
        mk_y = {dp, p[0], p[1], p[2], p[3], p[4], p[5], p[6]};
    endfunction

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge Clk);
        #1;
    endtask

    task automatic show_raw(input logic [3:0] sg, input logic [6:0] p, input logic dp, input int n);
        SEG = sg;
        y   = mk_y(p, dp);
        wait_cyc(n);
    endtask

    task automatic show(input logic [3:0] sg, input int d, input logic dp, input int n);
        show_raw(sg, pat(d), dp, n);
    endtask

    initial begin
        wait_cyc(3);
        chk("rst_q", 32'(Q), 32'h0);
        chk("rst_dp", 32'(DP), 32'h0);
        chk("rst_valid", 32'(Valid), 32'h0);
        chk("rst_err", 32'(Err), 32'h0);
        chk("rst_stale", 32'(Stale), 32'h0);
        RES = 1'b1;
        wait_cyc(10);

        // Clean frame 4321 with dp on the top digit, exact Valid timing on the last digit
        v0 = vcnt;
        show(4'b0001, 1, 1'b0, 20);
        show(4'b0010, 2, 1'b0, 20);
        show(4'b0100, 3, 1'b0, 20);
        SEG = 4'b1000;
        y   = mk_y(pat(4), 1'b1);
        wait_cyc(7);
        chk("t1_valid_pre", 32'(Valid), 32'h0);
        wait_cyc(1);
        chk("t1_valid_rise", 32'(Valid), 32'h1);
        wait_cyc(1);
        chk("t1_valid_fall", 32'(Valid), 32'h0);
        wait_cyc(11);
        chk("t1_vcount", 32'(vcnt - v0), 32'd1);
        chk("t1_q", 32'(Q), 32'h4321);
        chk("t1_dp", 32'(DP), 32'h8);
        chk("t1_err", 32'(Err), 32'h0);

        // Invalid glyph on digit 2, then a clean 6789 frame
        v0 = vcnt;
        show(4'b0001, 1, 1'b0, 20);
        show(4'b0010, 2, 1'b0, 20);
        show_raw(4'b0100, 7'b1000001, 1'b0, 20);
        show(4'b1000, 4, 1'b0, 20);
        chk("t2_vcount", 32'(vcnt - v0), 32'd1);
        chk("t2_q", 32'(Q), 32'h4F21);
        chk("t2_dp", 32'(DP), 32'h0);
        chk("t2_err", 32'(Err), 32'h1);
        v0 = vcnt;
        show(4'b0001, 9, 1'b0, 20);
        show(4'b0010, 8, 1'b0, 20);
        show(4'b0100, 7, 1'b0, 20);
        show(4'b1000, 6, 1'b0, 20);
        chk("t2b_vcount", 32'(vcnt - v0), 32'd1);
        chk("t2b_q", 32'(Q), 32'h6789);
        chk("t2b_err", 32'(Err), 32'h0);

        // SETTLE-long glitch onto digit 2 must not mark it seen
        v0 = vcnt;
        show(4'b0001, 5, 1'b0, 20);
        show(4'b0010, 6, 1'b0, 20);
        show(4'b0100, 8, 1'b0, SETTLE);
        show(4'b0010, 6, 1'b0, 20);
        show(4'b1000, 9, 1'b0, 20);
        chk("t3_no_valid", 32'(vcnt - v0), 32'd0);
        chk("t3_q_hold", 32'(Q), 32'h6789);
        show(4'b0100, 7, 1'b0, 20);
        chk("t3_vcount", 32'(vcnt - v0), 32'd1);
        chk("t3_q", 32'(Q), 32'h9765);
        chk("t3_err", 32'(Err), 32'h0);

        // Two digit selects at once flags the frame; next frame is clean again
        v0 = vcnt;
        show(4'b0001, 1, 1'b0, 20);
        show(4'b0011, 5, 1'b0, 20);
        show(4'b0010, 2, 1'b0, 20);
        show(4'b0100, 3, 1'b0, 20);
        show(4'b1000, 4, 1'b0, 20);
        chk("t4_vcount", 32'(vcnt - v0), 32'd1);
        chk("t4_q", 32'(Q), 32'h4321);
        chk("t4_err", 32'(Err), 32'h1);
        v0 = vcnt;
        show(4'b0001, 5, 1'b0, 20);
        show(4'b0010, 6, 1'b0, 20);
        show(4'b0100, 7, 1'b0, 20);
        show(4'b1000, 8, 1'b1, 20);
        chk("t4b_vcount", 32'(vcnt - v0), 32'd1);
        chk("t4b_q", 32'(Q), 32'h8765);
        chk("t4b_dp", 32'(DP), 32'h8);
        chk("t4b_err", 32'(Err), 32'h0);

        // Frozen scan: capture lands 7 cycles after the drive, Stale TIMEOUT cycles later
        v0 = vcnt;
        SEG = 4'b0001;
        y   = mk_y(pat(1), 1'b0);
        wait_cyc(106);
        chk("t5_stale_pre", 32'(Stale), 32'h0);
        wait_cyc(1);
        chk("t5_stale_rise", 32'(Stale), 32'h1);
        wait_cyc(3);
        chk("t5_stale_hold", 32'(Stale), 32'h1);
        SEG = 4'b0010;
        y   = mk_y(pat(2), 1'b0);
        wait_cyc(6);
        chk("t5_stale_still", 32'(Stale), 32'h1);
        wait_cyc(1);
        chk("t5_stale_drop", 32'(Stale), 32'h0);
        wait_cyc(13);
        chk("t5_no_valid", 32'(vcnt - v0), 32'd0);

        // Reset with three digits seen: outputs clear at once, no partial frame survives
        show(4'b0100, 3, 1'b0, 20);
        RES = 1'b0;
        #1;
        chk("t6_rst_q", 32'(Q), 32'h0);
        chk("t6_rst_dp", 32'(DP), 32'h0);
        chk("t6_rst_valid", 32'(Valid), 32'h0);
        chk("t6_rst_err", 32'(Err), 32'h0);
        chk("t6_rst_stale", 32'(Stale), 32'h0);
        SEG = '0;
        y   = '0;
        wait_cyc(3);
        RES = 1'b1;
        wait_cyc(10);
        v0 = vcnt;
        show(4'b1000, 9, 1'b0, 20);
        chk("t6_no_valid", 32'(vcnt - v0), 32'd0);
        chk("t6_q_zero", 32'(Q), 32'h0);
        show(4'b0001, 5, 1'b0, 20);
        show(4'b0010, 6, 1'b0, 20);
        show(4'b0100, 7, 1'b0, 20);
        chk("t6_vcount", 32'(vcnt - v0), 32'd1);
        chk("t6_q", 32'(Q), 32'h9765);
        chk("t6_dp", 32'(DP), 32'h0);
        chk("t6_err", 32'(Err), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
